mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the core's single memory port between instruction fetch (I side) and load/store access (D side, driven by the decoded memread/memwrite controls). It grants one single-beat transaction at a time, registers the winning request onto the memory port, and returns the response to the granted requester only. It sits between the fetch/memory stages and the memory bus, inside the pipeline top.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- i_valid  in  1  fetch request pending; held high until i_ready
- i_addr  in  ADDR_W  fetch address; stable while i_valid
- i_ready  out  1  one-cycle fetch completion pulse
- i_rdata  out  DATA_W  fetch data; valid when i_ready
- d_valid  in  1  load/store request pending; held high until d_ready
- d_write  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_size  in  3  access size code, passed through
- d_strobe  in  DATA_W/8  byte write enables; ignored for loads
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle data completion pulse
- d_rdata  out  DATA_W  load data; valid when d_ready
- m_valid  out  1  memory request valid
- m_write  out  1  memory request is a write
- m_addr  out  ADDR_W  memory address
- m_size  out  3  memory size code (I side always 3'b011)
- m_strobe  out  DATA_W/8  memory byte enables (all zero for reads)
- m_wdata  out  DATA_W  memory write data
- m_ready  in  1  memory completion; m_rdata valid in same cycle
- m_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE: if only d_valid -> BUSY_D; if only i_valid -> BUSY_I; if both -> D wins unless last_grant_d = 1, then I wins; neither -> stay.
- On grant: capture request into m_* registers; set last_grant_d = (winner is D).
- BUSY_x: m_valid = 1, m_* constant; on m_ready capture m_rdata into response register, go to RESP_x; else stay (no timeout).
- RESP_x: x_ready = 1 for exactly this cycle, x_rdata = captured data; m_valid = 0; -> IDLE.
- Non-granted requester sees ready = 0 and rdata = 0; its request remains pending.
- I-side grant: m_write = 0, m_strobe = 0, m_wdata = 0, m_size = 3'b011.
- D-side load: m_strobe forced to 0 regardless of d_strobe.
- Requester dropping valid while its transaction is in BUSY does not cancel it; response still issued.
- reset: state = IDLE, last_grant_d = 0, all outputs 0 immediately (asynchronous), in-flight transaction abandoned.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Request visible in IDLE at cycle 0 -> m_valid high from cycle 1.
- m_ready sampled at cycle k -> x_ready high in cycle k+1 only; minimum request-to-ready latency 2 cycles (m_ready at cycle 1).
- After RESP cycle, IDLE for one cycle; earliest next m_valid is 2 cycles after the ready pulse; requester updates valid at the ready edge so the IDLE cycle sees new request state.
- Both requesters continuously pending: grants strictly alternate D, I, D, I, ...
- m_ready while not in BUSY is ignored.

## Test plan
- Reset: assert reset mid-BUSY_D with m_valid = 1 -> m_valid, d_ready, i_ready all 0 in same cycle; after release, i_valid = 1, i_addr = 0x8000_0000 -> m_valid at next cycle with m_addr = 0x8000_0000, m_write = 0, m_size = 3'b011.
- Single fetch: i_valid at cycle 0, m_ready at cycle 3 with m_rdata = 0x0000_0013_0000_0093 -> i_ready = 1 only in cycle 4, i_rdata = that value, d_ready stays 0.
- Store: d_valid, d_write = 1, d_addr = 0x8000_1008, d_strobe = 0xF0, d_wdata = 0x1122_3344_5566_7788 -> m_* carry those exact values; d_ready one pulse after m_ready.
- Load strobe masking: d_write = 0, d_strobe = 0xFF -> m_strobe = 0x00, m_write = 0.
- Contention: i_valid and d_valid both held, memory answers every BUSY cycle immediately -> grant order D, I, D, I over four transactions; m_* stable throughout each BUSY period when m_ready delayed 5 cycles.
- Early drop: d_valid deasserted during BUSY_D -> transaction completes, d_ready still pulses once, then IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch/LSU requesters, the arbiter
// and the single memory port.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  i_valid;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_ready;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_valid;
    logic                  d_write;
    logic [ADDR_W-1:0]     d_addr;
    logic [2:0]            d_size;
    logic [DATA_W/8-1:0]   d_strobe;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_ready;
    logic [DATA_W-1:0]     d_rdata;

    logic                  m_valid;
    logic                  m_write;
    logic [ADDR_W-1:0]     m_addr;
    logic [2:0]            m_size;
    logic [DATA_W/8-1:0]   m_strobe;
    logic [DATA_W-1:0]     m_wdata;
    logic                  m_ready;
    logic [DATA_W-1:0]     m_rdata;

    modport slave (
        input  i_valid, i_addr,
        output i_ready, i_rdata,
        input  d_valid, d_write, d_addr, d_size, d_strobe, d_wdata,
        output d_ready, d_rdata,
        output m_valid, m_write, m_addr, m_size, m_strobe, m_wdata,
        input  m_ready, m_rdata
    );

    modport master (
        output i_valid, i_addr,
        input  i_ready, i_rdata,
        output d_valid, d_write, d_addr, d_size, d_strobe, d_wdata,
        input  d_ready, d_rdata,
        input  m_valid, m_write, m_addr, m_size, m_strobe, m_wdata,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-beat memory port between instruction fetch and
// load/store; alternating priority when both sides are pending.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t              r_state;
    logic                r_last_d;
    logic                r_m_valid;
    logic                r_m_write;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [2:0]          r_m_size;
    logic [STRB_W-1:0]   r_m_strobe;
    logic [DATA_W-1:0]   r_m_wdata;
    logic                r_i_ready;
    logic [DATA_W-1:0]   r_i_rdata;
    logic                r_d_ready;
    logic [DATA_W-1:0]   r_d_rdata;

    logic                w_grant_d;
    logic                w_grant_i;

    // D wins a tie unless it won the previous grant
    assign w_grant_d = bus.d_valid && (!bus.i_valid || !r_last_d);
    assign w_grant_i = bus.i_valid && !w_grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_d   <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_write  <= 1'b0;
            r_m_addr   <= '0;
            r_m_size   <= '0;
            r_m_strobe <= '0;
            r_m_wdata  <= '0;
            r_i_ready  <= 1'b0;
            r_i_rdata  <= '0;
            r_d_ready  <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state    <= BUSY_D;
                        r_last_d   <= 1'b1;
                        r_m_valid  <= 1'b1;
                        r_m_write  <= bus.d_write;
                        r_m_addr   <= bus.d_addr;
                        r_m_size   <= bus.d_size;
                        r_m_strobe <= bus.d_write ? bus.d_strobe : '0;
                        r_m_wdata  <= bus.d_wdata;
                    end else if (w_grant_i) begin
                        r_state    <= BUSY_I;
                        r_last_d   <= 1'b0;
                        r_m_valid  <= 1'b1;
                        r_m_write  <= 1'b0;
                        r_m_addr   <= bus.i_addr;
                        r_m_size   <= 3'b011;
                        r_m_strobe <= '0;
                        r_m_wdata  <= '0;
                    end
                end
                BUSY_I: begin
                    if (bus.m_ready) begin
                        r_state   <= RESP_I;
                        r_m_valid <= 1'b0;
                        r_i_ready <= 1'b1;
                        r_i_rdata <= bus.m_rdata;
                    end
                end
                BUSY_D: begin
                    if (bus.m_ready) begin
                        r_state   <= RESP_D;
                        r_m_valid <= 1'b0;
                        r_d_ready <= 1'b1;
                        r_d_rdata <= bus.m_rdata;
                    end
                end
                RESP_I: begin
                    r_state   <= IDLE;
                    r_i_ready <= 1'b0;
                    r_i_rdata <= '0;
                end
                RESP_D: begin
                    r_state   <= IDLE;
                    r_d_ready <= 1'b0;
                    r_d_rdata <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.m_valid  = r_m_valid;
    assign bus.m_write  = r_m_write;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_size   = r_m_size;
    assign bus.m_strobe = r_m_strobe;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.i_ready  = r_i_ready;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.d_ready  = r_d_ready;
    assign bus.d_rdata  = r_d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory
// requests and responses, a negedge monitor pops and compares them.
module tb_mem_arbiter;
    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [2:0]  sz;
        logic [7:0]  st;
        logic [63:0] wd;
    } req_t;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
    } rsp_t;

    typedef struct {
        int          dly;
        logic [63:0] data;
    } mem_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    mem_t mem_q[$];

    mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: answers each new request after its queued delay
    initial begin
        mem_t  e;
        bit    abort;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.m_valid && !reset) begin
                e.dly = 0;
                e.data = '0;
                if (mem_q.size() > 0) e = mem_q.pop_front();
                abort = 1'b0;
                for (int k = 0; k < e.dly; k++) begin
                    @(negedge clk);
                    if (!bus.m_valid) begin
                        abort = 1'b1;
                        break;
                    end
                end
                if (!abort) begin
                    bus.m_ready = 1'b1;
                    bus.m_rdata = e.data;
                    @(negedge clk);
                    bus.m_ready = 1'b0;
                    bus.m_rdata = '0;
                end
            end
        end
    end

    // Monitor
    bit   prev_mv = 1'b0;
    req_t snap;
    initial snap = '{1'b0, 64'h0, 3'h0, 8'h0, 64'h0};

    always @(negedge clk) begin
        req_t er;
        req_t got;
        rsp_t rr;
        logic [129:0] rgot;
        logic [129:0] rexp;
        if (reset) begin
            prev_mv = 1'b0;
        end else begin
            got = '{bus.m_write, bus.m_addr, bus.m_size,
                    bus.m_strobe, bus.m_wdata};
            if (bus.m_valid && !prev_mv) begin
                n_vec++;
                if (exp_req_q.size() == 0) begin
                    n_err++;
                    $display("FAIL m_req_unexpected addr=%h", bus.m_addr);
                end else begin
                    er = exp_req_q.pop_front();
                    if (got != er) begin
                        n_err++;
                        $display("FAIL m_req got w=%0b a=%h sz=%0d st=%h wd=%h exp w=%0b a=%h sz=%0d st=%h wd=%h",
                                 got.w, got.a, got.sz, got.st, got.wd,
                                 er.w, er.a, er.sz, er.st, er.wd);
                    end
                end
                snap = got;
            end else if (bus.m_valid) begin
                n_vec++;
                if (got != snap) begin
                    n_err++;
                    $display("FAIL m_stable got a=%h wd=%h exp a=%h wd=%h",
                             got.a, got.wd, snap.a, snap.wd);
                end
            end
            prev_mv = bus.m_valid;
            if (bus.i_ready || bus.d_ready) begin
                n_vec++;
                rgot = {bus.i_ready, bus.d_ready, bus.i_rdata, bus.d_rdata};
                if (exp_rsp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected got %h exp none", rgot);
                end else begin
                    rr = exp_rsp_q.pop_front();
                    if (rr.is_d) rexp = {1'b0, 1'b1, 64'h0, rr.data};
                    else         rexp = {1'b1, 1'b0, rr.data, 64'h0};
                    if (rgot !== rexp) begin
                        n_err++;
                        $display("FAIL rsp got %h exp %h", rgot, rexp);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rdy(input bit is_d);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_ready : bus.i_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout side_d=%0b got 0 exp 1", is_d);
        end
    endtask

    task automatic wait_mvalid();
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL m_valid_timeout got 0 exp 1");
        end
    endtask

    task automatic exp_i(input logic [63:0] a, input logic [63:0] rd,
                         input int dly);
        exp_req_q.push_back('{1'b0, a, 3'b011, 8'h00, 64'h0});
        mem_q.push_back('{dly, rd});
        exp_rsp_q.push_back('{1'b0, rd});
    endtask

    task automatic exp_d(input logic w, input logic [63:0] a,
                         input logic [2:0] sz, input logic [7:0] st,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input int dly);
        exp_req_q.push_back('{w, a, sz, st, wd});
        mem_q.push_back('{dly, rd});
        exp_rsp_q.push_back('{1'b1, rd});
    endtask

    task automatic set_i(input logic [63:0] a);
        bus.i_valid = 1'b1;
        bus.i_addr  = a;
    endtask

    task automatic set_d(input logic w, input logic [63:0] a,
                         input logic [2:0] sz, input logic [7:0] st,
                         input logic [63:0] wd);
        bus.d_valid  = 1'b1;
        bus.d_write  = w;
        bus.d_addr   = a;
        bus.d_size   = sz;
        bus.d_strobe = st;
        bus.d_wdata  = wd;
    endtask

    logic [63:0] ca_d [4];
    logic [63:0] ca_i [4];

    initial begin
        bus.i_valid = 1'b0;
        bus.i_addr = '0;
        bus.d_valid = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr = '0;
        bus.d_size = '0;
        bus.d_strobe = '0;
        bus.d_wdata = '0;
        ca_d = '{64'h8000_2000, 64'h8000_2008, 64'h8000_3000, 64'h8000_3008};
        ca_i = '{64'h8000_0100, 64'h8000_0104, 64'h8000_0200, 64'h8000_0204};

        tick(2);
        check("rst_m_valid", {63'h0, bus.m_valid}, 64'h0);
        check("rst_readys", {62'h0, bus.i_ready, bus.d_ready}, 64'h0);
        check("rst_m_addr", bus.m_addr, 64'h0);
        check("rst_m_wdata", bus.m_wdata, 64'h0);
        reset = 1'b0;
        tick(1);

        // Reset in the middle of a BUSY_D store
        exp_req_q.push_back('{1'b1, 64'h8000_0040, 3'b011, 8'hFF,
                              64'hDEAD_BEEF_0000_0001});
        mem_q.push_back('{20, 64'h0});
        set_d(1'b1, 64'h8000_0040, 3'b011, 8'hFF, 64'hDEAD_BEEF_0000_0001);
        wait_mvalid();
        tick(2);
        #2 reset = 1'b1;
        #1;
        check("midrst_m_valid", {63'h0, bus.m_valid}, 64'h0);
        check("midrst_d_ready", {63'h0, bus.d_ready}, 64'h0);
        check("midrst_i_ready", {63'h0, bus.i_ready}, 64'h0);
        bus.d_valid = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(1);
        exp_i(64'h8000_0000, 64'h0000_0000_0000_0013, 0);
        set_i(64'h8000_0000);
        tick(1);
        check("postrst_m_valid", {63'h0, bus.m_valid}, 64'h1);
        wait_rdy(1'b0);
        bus.i_valid = 1'b0;
        tick(2);

        // Store
        exp_d(1'b1, 64'h8000_1008, 3'b011, 8'hF0,
              64'h1122_3344_5566_7788, 64'h0, 1);
        set_d(1'b1, 64'h8000_1008, 3'b011, 8'hF0, 64'h1122_3344_5566_7788);
        wait_rdy(1'b1);
        bus.d_valid = 1'b0;
        tick(2);

        // Load: strobe masked
        exp_d(1'b0, 64'h8000_1010, 3'b010, 8'h00, 64'h0,
              64'hCAFE_F00D_1234_5678, 0);
        set_d(1'b0, 64'h8000_1010, 3'b010, 8'hFF, 64'h0);
        wait_rdy(1'b1);
        bus.d_valid = 1'b0;
        tick(2);

        // Early drop during BUSY_D
        exp_d(1'b0, 64'h8000_1018, 3'b011, 8'h00, 64'h0,
              64'hA5A5_5A5A_0F0F_F0F0, 3);
        set_d(1'b0, 64'h8000_1018, 3'b011, 8'h0F, 64'h0);
        wait_mvalid();
        bus.d_valid = 1'b0;
        wait_rdy(1'b1);
        tick(3);

        // Single fetch, m_ready at cycle 3
        exp_i(64'h8000_0004, 64'h0000_0013_0000_0093, 2);
        set_i(64'h8000_0004);
        wait_rdy(1'b0);
        bus.i_valid = 1'b0;
        tick(2);

        // Contention: both pending, zero then five cycles of memory delay
        for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < 2; t++) begin
                exp_d(1'b1, ca_d[2*p+t], 3'b011, 8'h0F,
                      64'h5000_0000_0000_0000 + 64'(2*p+t),
                      64'hD000_0000_0000_0000 + 64'(2*p+t), 5*p);
                exp_i(ca_i[2*p+t],
                      64'h1000_0000_0000_0000 + 64'(2*p+t), 5*p);
            end
            fork
                begin
                    for (int t = 0; t < 2; t++) begin
                        set_d(1'b1, ca_d[2*p+t], 3'b011, 8'h0F,
                              64'h5000_0000_0000_0000 + 64'(2*p+t));
                        wait_rdy(1'b1);
                    end
                    bus.d_valid = 1'b0;
                end
                begin
                    for (int t = 0; t < 2; t++) begin
                        set_i(ca_i[2*p+t]);
                        wait_rdy(1'b0);
                    end
                    bus.i_valid = 1'b0;
                end
            join
            tick(3);
        end

        tick(5);
        check("req_q_left", 64'(exp_req_q.size()), 64'h0);
        check("rsp_q_left", 64'(exp_rsp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
